// File: rtl/dm_pkg.sv
// Shared types for the debug-module hart run-control slice.
// Optional request timeout is enabled with DM_HALT_TIMEOUT_EN.
package dm_pkg;

    typedef enum logic [1:0] {
        RUNNING,
        HALTING,
        HALTED,
        RESUMING
    } dm_hart_state_e;

    localparam int DM_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/dm_req_timer.sv
// Saturating outstanding-request counter for hart run control.
// Used by dm_hart_ctl only when DM_HALT_TIMEOUT_EN is defined.
module dm_req_timer
    import dm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/dm_hart_ctl.sv
// Debug-module side of the hart halt/resume handshake.
// Request timeout flag is built only with DM_HALT_TIMEOUT_EN.
module dm_hart_ctl
    import dm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic dmactive,
    input  logic haltreq,
    input  logic resumereq,
    input  logic hart_halted,
    output logic halt_req,
    output logic resume_req,
    output logic st_halted,
    output logic st_running,
    output logic st_resumeack,
    output logic st_timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // A cleared dmactive is indistinguishable from reset.
    logic sync_rst;
    assign sync_rst = rst | ~dmactive;

    dm_hart_state_e state_q;
    dm_hart_state_e state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUNNING: begin
                if (hart_halted)
                    state_d = HALTED;
                else if (haltreq)
                    state_d = HALTING;
            end
            HALTING: begin
                if (hart_halted)
                    state_d = HALTED;
                else if (!haltreq)
                    state_d = RUNNING;
            end
            HALTED: begin
                if (resumereq && !haltreq)
                    state_d = RESUMING;
                else if (!hart_halted)
                    state_d = RUNNING;
            end
            RESUMING: begin
                if (!hart_halted)
                    state_d = RUNNING;
            end
            default: state_d = RUNNING;
        endcase
    end

    // Outputs decode the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q      <= RUNNING;
            halt_req     <= 1'b0;
            resume_req   <= 1'b0;
            st_halted    <= 1'b0;
            st_running   <= 1'b1;
            st_resumeack <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_req   <= (state_d == HALTING);
            resume_req <= (state_d == RESUMING);
            st_halted  <= (state_d == HALTED)
                       || (state_d == RESUMING);
            st_running <= (state_d == RUNNING)
                       || (state_d == HALTING);
            if (state_q == HALTED && state_d == RESUMING)
                st_resumeack <= 1'b0;
            else if (state_q == RESUMING && state_d == RUNNING)
                st_resumeack <= 1'b1;
        end
    end

`ifdef DM_HALT_TIMEOUT_EN
    logic req_active;
    logic req_entry;
    logic state_chg;
    logic expired;

    assign req_active = (state_q == HALTING)
                     || (state_q == RESUMING);
    assign state_chg  = (state_d != state_q);
    assign req_entry  = state_chg
                     && ((state_d == HALTING)
                      || (state_d == RESUMING));

    dm_req_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (sync_rst),
        .clear  (state_chg),
        .run    (req_active),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (sync_rst || req_entry)
            st_timeout <= 1'b0;
        else if (expired && req_active)
            st_timeout <= 1'b1;
    end
`else
    assign st_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dm_hart_ctl.sv
// Directed self-checking bench for dm_hart_ctl.
// Timeout expectations follow DM_HALT_TIMEOUT_EN.
module tb_dm_hart_ctl;

    logic clk = 1'b0;
    logic rst;
    logic dmactive;
    logic haltreq;
    logic resumereq;
    logic hart_halted;
    logic halt_req;
    logic resume_req;
    logic st_halted;
    logic st_running;
    logic st_resumeack;
    logic st_timeout;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [5:0] RST_OUT = 6'b000100;

`ifdef DM_HALT_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    dm_hart_ctl #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dmactive    (dmactive),
        .haltreq     (haltreq),
        .resumereq   (resumereq),
        .hart_halted (hart_halted),
        .halt_req    (halt_req),
        .resume_req  (resume_req),
        .st_halted   (st_halted),
        .st_running  (st_running),
        .st_resumeack(st_resumeack),
        .st_timeout  (st_timeout)
    );

    function automatic logic [5:0] outs();
        return {halt_req, resume_req, st_halted,
                st_running, st_resumeack, st_timeout};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        dmactive    = 1'b0;
        haltreq     = 1'b0;
        resumereq   = 1'b0;
        hart_halted = 1'b0;
        step();
        step();
        rst      = 1'b0;
        dmactive = 1'b1;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle", 32'(outs()), 32'(RST_OUT));
        end

        // requested halt, core acks in third request cycle
        haltreq = 1'b1;
        step();
        chk("hreq_c1", 32'(halt_req), 1);
        step();
        chk("hreq_c2", 32'(halt_req), 1);
        step();
        chk("hreq_c3", 32'(halt_req), 1);
        chk("hreq_run", 32'(st_running), 1);
        hart_halted = 1'b1;
        step();
        chk("hack", 32'(outs()), 32'(6'b001000));
        haltreq = 1'b0;
        step();
        chk("halted_hold", 32'(outs()), 32'(6'b001000));

        // resume blocked by haltreq
        haltreq   = 1'b1;
        resumereq = 1'b1;
        step();
        resumereq = 1'b0;
        chk("rblk_c1", 32'(outs()), 32'(6'b001000));
        step();
        chk("rblk_c2", 32'(outs()), 32'(6'b001000));
        haltreq = 1'b0;
        step();

        // resume, core drops halted while resume_req high
        resumereq = 1'b1;
        step();
        resumereq = 1'b0;
        chk("rreq", 32'(outs()), 32'(6'b011000));
        hart_halted = 1'b0;
        step();
        chk("rack", 32'(outs()), 32'(6'b000110));
        step();
        chk("rack_hold", 32'(outs()), 32'(6'b000110));

        // stray resume strobe in RUNNING
        resumereq = 1'b1;
        step();
        resumereq = 1'b0;
        chk("rstray", 32'(outs()), 32'(6'b000110));

        // self-halt (ebreak) then unrequested drop
        hart_halted = 1'b1;
        step();
        chk("ebreak", 32'(outs()), 32'(6'b001010));
        step();
        chk("ebreak_hold", 32'(outs()), 32'(6'b001010));
        hart_halted = 1'b0;
        step();
        chk("selfrun", 32'(outs()), 32'(6'b000110));

        // withdrawn halt request
        haltreq = 1'b1;
        step();
        chk("wd_req", 32'(outs()), 32'(6'b100110));
        haltreq = 1'b0;
        step();
        chk("wd_drop", 32'(outs()), 32'(6'b000110));

        // stuck halt: timeout after 8 cycles in HALTING
        haltreq = 1'b1;
        step();
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 7)
                chk("to_early", 32'(st_timeout), 0);
            if (i == 9) begin
                chk("to_set", 32'(st_timeout),
                    32'(TO_EN));
                chk("to_hreq", 32'(halt_req), 1);
            end
        end

        // dmactive low mid-handshake
        dmactive = 1'b0;
        step();
        chk("dmact_off", 32'(outs()), 32'(RST_OUT));
        step();
        chk("dmact_hold", 32'(outs()), 32'(RST_OUT));
        dmactive = 1'b1;
        haltreq  = 1'b0;
        step();
        chk("dmact_on", 32'(outs()), 32'(RST_OUT));

        // synchronous reset drops halt_req
        haltreq = 1'b1;
        step();
        chk("pre_rst", 32'(halt_req), 1);
        rst = 1'b1;
        step();
        chk("mid_rst", 32'(outs()), 32'(RST_OUT));
        rst     = 1'b0;
        haltreq = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks",
                 n_err, n_chk);
        $finish;
    end

    always @(negedge clk) begin
        if (!rst && dmactive) begin
            n_chk++;
            if ((st_halted ^ st_running) !== 1'b1) begin
                n_err++;
                $display("FAIL excl: h=%b r=%b exp one-hot",
                         st_halted, st_running);
            end
            n_chk++;
            if ((halt_req & resume_req) !== 1'b0) begin
                n_err++;
                $display("FAIL both_req: got=1 exp=0");
            end
        end
    end

endmodule
